// File: rtl/btn_debounce.sv
// btn_debounce: multi-channel push-button conditioner.
// Each raw button is synchronised, then debounced by a tick-sampled shift register.
// Each channel emits a clean level plus one-cycle rise and fall pulses.
// Optional long-press detection is built when BTN_LONGPRESS_EN is defined.
// Without that macro, o_long is tied to 0.
module btn_debounce #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned SAMPLE_HZ  = 1_000,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned N_BTN      = 2,
  parameter int unsigned LONG_TICKS = 1_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_rise,
  output logic [N_BTN-1:0] o_fall,
  output logic [N_BTN-1:0] o_long
);

  localparam int unsigned DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

  // Reject configurations that cannot debounce meaningfully.
  if (DIV < 2) begin : g_div_chk
    $error("btn_debounce: CLK_HZ/SAMPLE_HZ must be >= 2");
  end
  if (DEPTH < 2) begin : g_depth_chk
    $error("btn_debounce: DEPTH must be >= 2");
  end
  if (LONG_TICKS < 1) begin : g_long_chk
    $error("btn_debounce: LONG_TICKS must be >= 1");
  end

  logic [N_BTN-1:0]            sync1_q, sync2_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        tick;
  logic [N_BTN-1:0][DEPTH-1:0] shreg_q, shreg_d;
  logic [N_BTN-1:0]            level_q, level_d;
  logic [N_BTN-1:0]            rise_q, rise_d;
  logic [N_BTN-1:0]            fall_q, fall_d;

  // Shared sample tick and per-channel shift/level decisions.
  // The level update uses the freshly shifted value, so it lands on the tick edge itself.
  always_comb begin
    tick    = (cnt_q == CNT_W'(DIV - 1));
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    shreg_d = shreg_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (tick) begin
        shreg_d[i] = {shreg_q[i][DEPTH-2:0], sync2_q[i]};
        if ((&shreg_d[i]) && !level_q[i]) begin
          level_d[i] = 1'b1;
          rise_d[i]  = 1'b1;
        end else if (!(|shreg_d[i]) && level_q[i]) begin
          level_d[i] = 1'b0;
          fall_d[i]  = 1'b1;
        end
      end
    end
  end

  // Synchroniser, tick counter, shift registers and registered level/pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

`ifdef BTN_LONGPRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);

  logic [N_BTN-1:0][HOLD_W-1:0] hold_q, hold_d;
  logic [N_BTN-1:0]             long_q, long_d;

  // Count held ticks after a rise. The counter saturates so only one long pulse occurs per press.
  always_comb begin
    hold_d = hold_q;
    long_d = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (!level_q[i] || rise_q[i]) begin
        hold_d[i] = '0;
      end else if (tick && (hold_q[i] != HOLD_W'(LONG_TICKS))) begin
        hold_d[i] = hold_q[i] + HOLD_W'(1);
        if (hold_q[i] == HOLD_W'(LONG_TICKS - 1)) begin
          long_d[i] = 1'b1;
        end
      end
    end
  end

  // Hold counters and registered long-press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= '0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign o_long = long_q;
`else
  assign o_long = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed and randomised checks of btn_debounce against a run-length reference model.
module tb_btn_debounce;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;
  localparam int LONGT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] i_btn;
  logic [1:0] o_level, o_rise, o_fall, o_long;

  int checks = 0;
  int errors = 0;
  int tcyc   = 0;
  int t0;
  int rise_cnt[2], fall_cnt[2], long_cnt[2];
  int rise_t[2], fall_t[2], long_t[2];

  btn_debounce #(
    .CLK_HZ(1000), .SAMPLE_HZ(100), .DEPTH(DEPTH), .N_BTN(2), .LONG_TICKS(LONGT)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall), .o_long(o_long)
  );

  always #5 clk = ~clk;

  // Reference model: inputs pass through a two-cycle delay, and samples are taken every DIV cycles.
  // The level follows the sample value once a run of DEPTH equal samples exists.
  logic [1:0] m_d1, m_d2, m_lvl, m_rise, m_fall, m_long;
  logic       m_run_val[2];
  int         m_run_len[2];
  int         m_cyc;
  int         m_rise_e[2];
  logic       m_tick;

  always @(posedge clk) begin
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0;
      m_rise = '0; m_fall = '0; m_long = '0;
      m_cyc = 0;
      for (int c = 0; c < 2; c++) begin
        m_run_val[c] = 1'b0;
        m_run_len[c] = DEPTH;
        m_rise_e[c]  = -1000000;
      end
    end else begin
      m_tick = ((m_cyc % DIV) == DIV - 1);
      m_cyc++;
      m_rise = '0; m_fall = '0; m_long = '0;
      for (int c = 0; c < 2; c++) begin
`ifdef BTN_LONGPRESS_EN
        if (m_lvl[c] && (m_cyc - m_rise_e[c] == LONGT * DIV)) m_long[c] = 1'b1;
`endif
        if (m_tick) begin
          if (m_d2[c] == m_run_val[c]) begin
            if (m_run_len[c] < DEPTH) m_run_len[c]++;
          end else begin
            m_run_val[c] = m_d2[c];
            m_run_len[c] = 1;
          end
          if (m_run_len[c] == DEPTH && m_run_val[c] != m_lvl[c]) begin
            m_lvl[c] = m_run_val[c];
            if (m_run_val[c]) begin
              m_rise[c]   = 1'b1;
              m_rise_e[c] = m_cyc;
            end else begin
              m_fall[c] = 1'b1;
            end
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = i_btn;
    end
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, tcyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < 2; c++) begin
      rise_cnt[c] = 0; fall_cnt[c] = 0; long_cnt[c] = 0;
      rise_t[c] = -1; fall_t[c] = -1; long_t[c] = -1;
    end
  endtask

  // Advance n cycles, compare against the model, and log pulse events.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      tcyc++;
      chk("level", o_level, m_lvl);
      chk("rise", o_rise, m_rise);
      chk("fall", o_fall, m_fall);
      chk("long", o_long, m_long);
      for (int c = 0; c < 2; c++) begin
        if (o_rise[c]) begin rise_cnt[c]++; rise_t[c] = tcyc; end
        if (o_fall[c]) begin fall_cnt[c]++; fall_t[c] = tcyc; end
        if (o_long[c]) begin long_cnt[c]++; long_t[c] = tcyc; end
      end
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    i_btn = 2'b00;
    step(2);
    rst = 1'b0;
    step(int'($urandom_range(20, 40)));
  endtask

  initial begin
    int g;
    // 1: reset with both buttons held, then exactly one rise per channel.
    rst   = 1'b1;
    i_btn = 2'b11;
    step(3);
    chk("rst_level", o_level, 2'b00);
    chk("rst_rise", o_rise, 2'b00);
    rst = 1'b0;
    clr();
    t0 = tcyc;
    step(60);
    chk_int("t1_rise0_cnt", rise_cnt[0], 1);
    chk_int("t1_rise1_cnt", rise_cnt[1], 1);
    chk_rng("t1_rise0_lat", rise_t[0] - t0, 33, 43);
    chk_rng("t1_rise1_lat", rise_t[1] - t0, 33, 43);

    // 2: clean step on channel 0.
    do_reset();
    i_btn = 2'b01;
    clr();
    t0 = tcyc;
    step(100);
    chk_int("t2_rise0_cnt", rise_cnt[0], 1);
    chk_int("t2_fall0_cnt", fall_cnt[0], 0);
    chk_int("t2_rise1_cnt", rise_cnt[1], 0);
    chk_rng("t2_rise0_lat", rise_t[0] - t0, 33, 43);
    chk("t2_level", o_level, 2'b01);

    // 3: chatter every 7 cycles, then held high.
    do_reset();
    clr();
    for (int k = 0; k < 60; k++) begin
      if (k % 7 == 0) i_btn[0] = ~i_btn[0];
      step(1);
    end
    i_btn[0] = 1'b1;
    step(80);
    chk_int("t3_rise0_cnt", rise_cnt[0], 1);
    chk_int("t3_fall0_cnt", fall_cnt[0], 0);
    chk("t3_level", o_level, 2'b01);

    // 4: release, then a short high glitch that must be ignored.
    i_btn[0] = 1'b0;
    clr();
    t0 = tcyc;
    step(60);
    chk_int("t4_fall0_cnt", fall_cnt[0], 1);
    chk_rng("t4_fall0_lat", fall_t[0] - t0, 33, 43);
    g = int'($urandom_range(5, 25));
    clr();
    i_btn[0] = 1'b1;
    step(g);
    i_btn[0] = 1'b0;
    step(60);
    chk_int("t4_glitch_rise0", rise_cnt[0], 0);
    chk("t4_level", o_level, 2'b00);

    // 5: simultaneous press on both channels.
    i_btn = 2'b11;
    clr();
    step(60);
    chk_int("t5_rise0_cnt", rise_cnt[0], 1);
    chk_int("t5_rise1_cnt", rise_cnt[1], 1);
    chk_int("t5_same_cycle", rise_t[1], rise_t[0]);

    // 6: long hold on channel 0.
    i_btn = 2'b00;
    step(60);
    i_btn = 2'b01;
    clr();
    step(200);
    chk_int("t6_rise0_cnt", rise_cnt[0], 1);
`ifdef BTN_LONGPRESS_EN
    chk_int("t6_long0_cnt", long_cnt[0], 1);
    chk_int("t6_long0_delay", long_t[0] - rise_t[0], LONGT * DIV);
`else
    chk_int("t6_long0_cnt", long_cnt[0], 0);
`endif
    chk_int("t6_long1_cnt", long_cnt[1], 0);

    // 7: reset mid-operation with buttons held, then a single re-debounced rise.
    i_btn = 2'b11;
    step(60);
    rst = 1'b1;
    step(1);
    chk("t7_rst_level", o_level, 2'b00);
    chk("t7_rst_rise", o_rise, 2'b00);
    step(1);
    rst = 1'b0;
    clr();
    step(60);
    chk_int("t7_rise0_cnt", rise_cnt[0], 1);
    chk_int("t7_rise1_cnt", rise_cnt[1], 1);

    // 8: random chatter with occasional resets, checked cycle by cycle against the model.
    for (int r = 0; r < 60; r++) begin
      i_btn = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        step(int'($urandom_range(1, 3)));
        rst = 1'b0;
      end
      step(int'($urandom_range(1, 55)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
